// File: rtl/lidar_pkg.sv
// Shared definitions for the point-cloud cache scheduler.
//   N_DEFAULT / AW_DEFAULT : coordinate width and BRAM address width
//   sched_state_t          : scheduler FSM states
//   wrap_add               : (a + b) mod size, valid when a < size and b <= size
package lidar_pkg;

  localparam int N_DEFAULT                = 16;
  localparam int AW_DEFAULT               = 17;
  localparam int CORE_NUMBER_DEFAULT      = 16;
  localparam int DISTANCE_MODULES_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    CORE_FILL,
    FEED_FILL,
    FEED_OUT,
    PURGE,
    DONE
  } sched_state_t;

  function automatic logic [AW_DEFAULT-1:0] wrap_add(input logic [AW_DEFAULT-1:0] a,
                                                     input logic [AW_DEFAULT-1:0] b,
                                                     input logic [AW_DEFAULT-1:0] size);
    logic [AW_DEFAULT:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, size}) s = s - {1'b0, size};
    return s[AW_DEFAULT-1:0];
  endfunction

endpackage

// File: rtl/point_cache_scheduler_window_loader.sv
// window_loader: issues a run of count_i consecutive circular BRAM reads starting
// at base_i, and flags the cycle in which each read's data is on the bus.
//   clk, rst_n       : clock, async active-low reset
//   start_i          : (re)start a run; the first read is issued in the next cycle
//   abort_i          : stop issuing and drop any pending capture
//   base_i, size_i   : first address, cloud size (wrap modulus)
//   count_i          : number of reads in the run (>= 1)
//   addr_o, en_o     : read address / enable (registered)
//   cap_o, slot_o    : read data for slot slot_o is valid this cycle
//   last_o           : the capture is the final slot of the run
module window_loader
  import lidar_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [AW-1:0] base_i,
  input  logic [AW-1:0] size_i,
  input  logic [SW-1:0] count_i,
  output logic [AW-1:0] addr_o,
  output logic          en_o,
  output logic          cap_o,
  output logic [SW-1:0] slot_o,
  output logic          last_o
);

  logic [AW-1:0] addr_q;
  logic          en_q;
  logic [SW-1:0] idx_q;
  logic [SW-1:0] cnt_q;
  logic          cap_q;
  logic [SW-1:0] cap_slot_q;
  logic          cap_last_q;
  logic          issue_last;

  assign issue_last = (idx_q == cnt_q - SW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      en_q       <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      cap_q      <= 1'b0;
      cap_slot_q <= '0;
      cap_last_q <= 1'b0;
    end else if (start_i) begin
      // A restart also discards the capture of a read still in flight.
      addr_q <= base_i;
      en_q   <= 1'b1;
      idx_q  <= '0;
      cnt_q  <= count_i;
      cap_q  <= 1'b0;
    end else if (abort_i) begin
      en_q  <= 1'b0;
      cap_q <= 1'b0;
    end else begin
      cap_q      <= en_q;
      cap_slot_q <= idx_q;
      cap_last_q <= issue_last;
      if (en_q) begin
        if (issue_last) begin
          // addr_q keeps the last issued address; the top derives the next window base from it.
          en_q <= 1'b0;
        end else begin
          idx_q  <= idx_q + SW'(1);
          addr_q <= wrap_add(addr_q, AW'(1), size_i);
        end
      end
    end
  end

  assign addr_o = addr_q;
  assign en_o   = en_q;
  assign cap_o  = cap_q;
  assign slot_o = cap_slot_q;
  assign last_o = cap_last_q;

endmodule

// File: rtl/point_cache_scheduler.sv
// point_cache_scheduler: owns the shared X/Y/Z BRAM port for the ROR controller.
// Loads the core cache, streams circular feeder windows, pauses the controller
// while windows load, and after controller_done_i pops the outlier FIFO and
// zeroes every listed point.
//   clk, rst_n                 : clock, async active-low reset
//   start_i                    : 1-cycle pulse, begins a run
//   point_cloud_size_i         : number of valid points (constant during a run)
//   point_pos_i                : controller's core base index
//   update_cache_i             : controller requests a core-cache reload
//   controller_done_i          : controller finished the cloud
//   fifo_empty_i, outlier_pos_i: outlier FIFO status / head (valid 1 cycle after pop)
//   mem_rdata_{x,y,z}_i        : BRAM read data, 1-cycle latency
//   mem_addr_o/en_o/we_o       : shared BRAM port; write data is zero
//   read_fifo_o                : pop outlier FIFO
//   cache_{x,y,z}_o            : core cache, slot k at [N*k +: N]
//   cache_feeder_{x,y,z}_o     : feeder window, same packing
//   cache_updated_o            : pulse when the core cache is complete
//   pause_o, done_o            : controller hold / run complete
module point_cache_scheduler
  import lidar_pkg::*;
#(
  parameter int N                = N_DEFAULT,
  parameter int CORE_NUMBER      = CORE_NUMBER_DEFAULT,
  parameter int DISTANCE_MODULES = DISTANCE_MODULES_DEFAULT,
  parameter int AW               = AW_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic [AW-1:0]                 point_cloud_size_i,
  input  logic [AW-1:0]                 point_pos_i,
  input  logic                          update_cache_i,
  input  logic                          controller_done_i,
  input  logic                          fifo_empty_i,
  input  logic [AW-1:0]                 outlier_pos_i,
  input  logic [N-1:0]                  mem_rdata_x_i,
  input  logic [N-1:0]                  mem_rdata_y_i,
  input  logic [N-1:0]                  mem_rdata_z_i,
  output logic [AW-1:0]                 mem_addr_o,
  output logic                          mem_en_o,
  output logic                          mem_we_o,
  output logic                          read_fifo_o,
  output logic [N*CORE_NUMBER-1:0]      cache_x_o,
  output logic [N*CORE_NUMBER-1:0]      cache_y_o,
  output logic [N*CORE_NUMBER-1:0]      cache_z_o,
  output logic [N*DISTANCE_MODULES-1:0] cache_feeder_x_o,
  output logic [N*DISTANCE_MODULES-1:0] cache_feeder_y_o,
  output logic [N*DISTANCE_MODULES-1:0] cache_feeder_z_o,
  output logic                          cache_updated_o,
  output logic                          pause_o,
  output logic                          done_o
);

  // state     | meaning
  // IDLE      | waiting for start, controller held
  // CORE_FILL | loading CORE_NUMBER points from point_pos_i
  // FEED_FILL | loading DISTANCE_MODULES points from feeder_pos_q
  // FEED_OUT  | single un-paused cycle, controller consumes the window
  // PURGE     | popping outlier FIFO, zeroing each popped point
  // DONE      | run complete, held until the next start

  localparam int KMAX = (CORE_NUMBER > DISTANCE_MODULES) ? CORE_NUMBER : DISTANCE_MODULES;
  localparam int SW   = $clog2(KMAX + 1);

  sched_state_t state_q, state_d;
  logic [AW-1:0] feeder_pos_q;
  logic          pause_q, done_q, cache_updated_q, wr_pend_q;
  logic [N*CORE_NUMBER-1:0]      cx_q, cy_q, cz_q;
  logic [N*DISTANCE_MODULES-1:0] fx_q, fy_q, fz_q;

  logic          ld_start, ld_abort, ld_en, ld_cap, ld_last;
  logic [AW-1:0] ld_base, ld_addr, feeder_next;
  logic [SW-1:0] ld_count, ld_slot;
  logic          cap_core, cap_feed, cache_upd_d, feed_reset, feed_adv;

  window_loader #(.AW(AW), .SW(SW)) u_loader (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (ld_start),
    .abort_i (ld_abort),
    .base_i  (ld_base),
    .size_i  (point_cloud_size_i),
    .count_i (ld_count),
    .addr_o  (ld_addr),
    .en_o    (ld_en),
    .cap_o   (ld_cap),
    .slot_o  (ld_slot),
    .last_o  (ld_last)
  );

  // One past the last feeder address is (feeder_pos + DISTANCE_MODULES) mod size,
  // even when the cloud is smaller than the window.
  assign feeder_next = wrap_add(ld_addr, AW'(1), point_cloud_size_i);

  always_comb begin
    state_d     = state_q;
    ld_start    = 1'b0;
    ld_abort    = 1'b0;
    ld_base     = point_pos_i;
    ld_count    = SW'(CORE_NUMBER);
    cap_core    = 1'b0;
    cap_feed    = 1'b0;
    cache_upd_d = 1'b0;
    feed_reset  = 1'b0;
    feed_adv    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          feed_reset = 1'b1;
          if (point_cloud_size_i == '0) begin
            state_d = PURGE;
          end else begin
            state_d  = CORE_FILL;
            ld_start = 1'b1;
            ld_base  = '0;
          end
        end
      end
      CORE_FILL: begin
        if (controller_done_i) begin
          state_d  = PURGE;
          ld_abort = 1'b1;
        end else if (ld_cap) begin
          cap_core = 1'b1;
          if (ld_last) begin
            state_d     = FEED_FILL;
            cache_upd_d = 1'b1;
            ld_start    = 1'b1;
            ld_base     = feeder_pos_q;
            ld_count    = SW'(DISTANCE_MODULES);
          end
        end
      end
      FEED_FILL: begin
        if (controller_done_i) begin
          state_d  = PURGE;
          ld_abort = 1'b1;
        end else if (update_cache_i) begin
          state_d  = CORE_FILL;
          ld_start = 1'b1;
        end else if (ld_cap) begin
          cap_feed = 1'b1;
          if (ld_last) state_d = FEED_OUT;
        end
      end
      FEED_OUT: begin
        if (controller_done_i) begin
          state_d  = PURGE;
          ld_abort = 1'b1;
        end else if (update_cache_i) begin
          state_d  = CORE_FILL;
          ld_start = 1'b1;
        end else begin
          state_d  = FEED_FILL;
          feed_adv = 1'b1;
          ld_start = 1'b1;
          ld_base  = feeder_next;
          ld_count = SW'(DISTANCE_MODULES);
        end
      end
      PURGE: begin
        if (fifo_empty_i && !wr_pend_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Combinational so the FIFO is never popped past its last entry.
  assign read_fifo_o = (state_q == PURGE) && !fifo_empty_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      feeder_pos_q    <= '0;
      pause_q         <= 1'b1;
      done_q          <= 1'b0;
      cache_updated_q <= 1'b0;
      wr_pend_q       <= 1'b0;
      cx_q            <= '0;
      cy_q            <= '0;
      cz_q            <= '0;
      fx_q            <= '0;
      fy_q            <= '0;
      fz_q            <= '0;
    end else begin
      state_q         <= state_d;
      pause_q         <= (state_d != FEED_OUT);
      done_q          <= (state_d == DONE);
      cache_updated_q <= cache_upd_d;
      wr_pend_q       <= read_fifo_o;
      if (feed_reset)    feeder_pos_q <= '0;
      else if (feed_adv) feeder_pos_q <= feeder_next;
      if (cap_core) begin
        cx_q[N*int'(ld_slot) +: N] <= mem_rdata_x_i;
        cy_q[N*int'(ld_slot) +: N] <= mem_rdata_y_i;
        cz_q[N*int'(ld_slot) +: N] <= mem_rdata_z_i;
      end
      if (cap_feed) begin
        fx_q[N*int'(ld_slot) +: N] <= mem_rdata_x_i;
        fy_q[N*int'(ld_slot) +: N] <= mem_rdata_y_i;
        fz_q[N*int'(ld_slot) +: N] <= mem_rdata_z_i;
      end
    end
  end

  // Outlier writes only happen in PURGE, where the loader is idle.
  assign mem_addr_o       = wr_pend_q ? outlier_pos_i : ld_addr;
  assign mem_en_o         = ld_en | wr_pend_q;
  assign mem_we_o         = wr_pend_q;
  assign cache_x_o        = cx_q;
  assign cache_y_o        = cy_q;
  assign cache_z_o        = cz_q;
  assign cache_feeder_x_o = fx_q;
  assign cache_feeder_y_o = fy_q;
  assign cache_feeder_z_o = fz_q;
  assign cache_updated_o  = cache_updated_q;
  assign pause_o          = pause_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_point_cache_scheduler.sv
module tb_point_cache_scheduler;
  localparam int N  = 16;
  localparam int CN = 16;
  localparam int DM = 16;
  localparam int AW = 17;
  localparam int W  = N * CN;

  logic clk = 1'b0;
  logic rst_n, start, update_cache, controller_done, fifo_empty;
  logic [AW-1:0] size, point_pos;
  logic [AW-1:0] outlier_pos = '0;
  logic [N-1:0] rdx, rdy, rdz;
  logic [AW-1:0] mem_addr;
  logic mem_en, mem_we, read_fifo, cache_updated, pause, done;
  logic [W-1:0] cache_x, cache_y, cache_z, feed_x, feed_y, feed_z;

  always #5 clk = ~clk;

  point_cache_scheduler #(.N(N), .CORE_NUMBER(CN), .DISTANCE_MODULES(DM), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .point_cloud_size_i(size),
    .point_pos_i(point_pos), .update_cache_i(update_cache),
    .controller_done_i(controller_done), .fifo_empty_i(fifo_empty),
    .outlier_pos_i(outlier_pos), .mem_rdata_x_i(rdx), .mem_rdata_y_i(rdy),
    .mem_rdata_z_i(rdz), .mem_addr_o(mem_addr), .mem_en_o(mem_en), .mem_we_o(mem_we),
    .read_fifo_o(read_fifo), .cache_x_o(cache_x), .cache_y_o(cache_y), .cache_z_o(cache_z),
    .cache_feeder_x_o(feed_x), .cache_feeder_y_o(feed_y), .cache_feeder_z_o(feed_z),
    .cache_updated_o(cache_updated), .pause_o(pause), .done_o(done)
  );

  // BRAM model: point i holds x=0x1000+i, y=0x2000+i, z=0x3000+i.
  logic [N-1:0] mx[64], my[64], mz[64];
  logic mem_loaded = 1'b0;
  logic [5:0] ma;
  assign ma = 6'(mem_addr);
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) begin
        mx[i] <= 16'h1000 + 16'(i);
        my[i] <= 16'h2000 + 16'(i);
        mz[i] <= 16'h3000 + 16'(i);
      end
      mem_loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        mx[ma] <= '0; my[ma] <= '0; mz[ma] <= '0;
      end else begin
        rdx <= mx[ma]; rdy <= my[ma]; rdz <= mz[ma];
      end
    end
  end

  // Outlier FIFO model: head appears one cycle after the pop.
  logic [AW-1:0] fifo_mem[4];
  int wr_cnt = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_cnt);
  always @(posedge clk) begin
    if (read_fifo && !fifo_empty) begin
      outlier_pos <= fifo_mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) tick();
  endtask

  // Expected 16-slot vector for window starting at base, modulo sz; which: 0=x 1=y 2=z.
  function automatic logic [W-1:0] exp_vec(input int base, input int sz, input int which,
                                           input bit purged);
    logic [W-1:0] v;
    int idx;
    logic [N-1:0] e;
    v = '0;
    for (int k = 0; k < 16; k++) begin
      idx = (base + k) % sz;
      e = 16'(16'h1000 * (which + 1) + idx);
      if (purged && (idx == 3 || idx == 17 || idx == 39)) e = '0;
      v[N*k +: N] = e;
    end
    return v;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"}, W'(mem_addr), '0);
    chk({tag, "_en"}, W'(mem_en), '0);
    chk({tag, "_we"}, W'(mem_we), '0);
    chk({tag, "_rdfifo"}, W'(read_fifo), '0);
    chk({tag, "_cupd"}, W'(cache_updated), '0);
    chk({tag, "_done"}, W'(done), '0);
    chk({tag, "_pause"}, W'(pause), W'(1));
    chk({tag, "_cache_x"}, cache_x, '0);
    chk({tag, "_feed_z"}, feed_z, '0);
  endtask

  bit flag;

  initial begin
    rst_n = 1'b0; start = 1'b0; update_cache = 1'b0; controller_done = 1'b0;
    size = AW'(40); point_pos = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    #2 rst_n = 1'b1;
    tick(); tick();
    chk("idle_pause", W'(pause), W'(1));

    // Test 1: core fill then first feeder window.
    start = 1'b1;
    tick(); cyc = 0; start = 1'b0;
    chk("t1_first_en", W'(mem_en), W'(1));
    chk("t1_first_addr", W'(mem_addr), W'(0));
    go_to(16);
    chk("t1_cupd_early", W'(cache_updated), '0);
    go_to(17);
    chk("t1_cupd", W'(cache_updated), W'(1));
    chk("t1_cache_x", cache_x, exp_vec(0, 40, 0, 0));
    chk("t1_cache_y", cache_y, exp_vec(0, 40, 1, 0));
    chk("t1_cache_z", cache_z, exp_vec(0, 40, 2, 0));
    chk("t1_feed_addr0", W'(mem_addr), W'(0));
    go_to(18);
    chk("t1_cupd_pulse", W'(cache_updated), '0);
    go_to(33);
    chk("t1_pause_before", W'(pause), W'(1));
    go_to(34);
    chk("t1_pause_low", W'(pause), '0);
    chk("t1_feed_x", feed_x, exp_vec(0, 40, 0, 0));
    go_to(35);
    chk("t1_pause_after", W'(pause), W'(1));
    chk("t1_next_base", W'(mem_addr), W'(16));

    // Test 2: third window wraps 32..39,0..7.
    go_to(53);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t2_addr%0d", i), W'(mem_addr), W'((32 + i) % 40));
      tick();
    end
    go_to(70);
    chk("t2_pause_low", W'(pause), '0);
    chk("t2_feed_x", feed_x, exp_vec(32, 40, 0, 0));
    go_to(71);
    chk("t2_next_base", W'(mem_addr), W'(8));

    // Test 3: update_cache while slot 5 of the window is issued.
    go_to(76);
    update_cache = 1'b1; point_pos = AW'(8);
    tick(); update_cache = 1'b0;
    chk("t3_core_addr", W'(mem_addr), W'(8));
    flag = 1'b0;
    while (cyc < 94) begin
      if (pause !== 1'b1) flag = 1'b1;
      tick();
    end
    chk("t3_no_pause_low", W'(flag), '0);
    chk("t3_cupd", W'(cache_updated), W'(1));
    chk("t3_cache_x", cache_x, exp_vec(8, 40, 0, 0));
    chk("t3_feeder_kept", W'(mem_addr), W'(8));
    go_to(111);
    chk("t3_pause_low", W'(pause), '0);
    chk("t3_feed_y", feed_y, exp_vec(8, 40, 1, 0));

    // Test 4: purge outliers {3,17,39}.
    go_to(112);
    fifo_mem[0] = AW'(3); fifo_mem[1] = AW'(17); fifo_mem[2] = AW'(39);
    wr_cnt = 3;
    go_to(115);
    controller_done = 1'b1;
    tick(); controller_done = 1'b0;
    chk("t4_rdfifo", W'(read_fifo), W'(1));
    chk("t4_no_we_yet", W'(mem_we), '0);
    chk("t4_pause", W'(pause), W'(1));
    go_to(117);
    chk("t4_we0", W'({mem_we, mem_en}), W'(3));
    chk("t4_addr0", W'(mem_addr), W'(3));
    go_to(118);
    chk("t4_we1", W'(mem_we), W'(1));
    chk("t4_addr1", W'(mem_addr), W'(17));
    go_to(119);
    chk("t4_we2", W'(mem_we), W'(1));
    chk("t4_addr2", W'(mem_addr), W'(39));
    chk("t4_rdfifo_off", W'(read_fifo), '0);
    go_to(120);
    chk("t4_we_off", W'(mem_we), '0);
    chk("t4_not_done", W'(done), '0);
    go_to(121);
    chk("t4_done", W'(done), W'(1));
    chk("t4_pause_done", W'(pause), W'(1));
    chk("t4_cache_kept", cache_x, exp_vec(8, 40, 0, 0));
    chk("t4_mem3", W'(mx[3]), '0);
    chk("t4_mem17", W'(mz[17]), '0);
    chk("t4_mem39", W'(my[39]), '0);
    chk("t4_mem4", W'(mx[4]), W'(16'h1004));
    go_to(124);
    chk("t4_done_held", W'(done), W'(1));

    // Test 5: cloud of 5 points, smaller than the window.
    size = AW'(5); point_pos = '0;
    start = 1'b1;
    tick(); cyc = 0; start = 1'b0;
    flag = 1'b0;
    while (cyc <= 35) begin
      if (mem_en === 1'b1 && mem_addr >= AW'(5)) flag = 1'b1;
      if (cyc == 1)  chk("t5_done_clr", W'(done), '0);
      if (cyc == 17) begin
        chk("t5_cupd", W'(cache_updated), W'(1));
        chk("t5_cache_x", cache_x, exp_vec(0, 5, 0, 1));
        chk("t5_cache_z", cache_z, exp_vec(0, 5, 2, 1));
      end
      if (cyc == 34) begin
        chk("t5_pause_low", W'(pause), '0);
        chk("t5_feed_x", feed_x, exp_vec(0, 5, 0, 1));
      end
      if (cyc == 35) chk("t5_next_base", W'(mem_addr), W'(1));
      tick();
    end
    chk("t5_addr_in_range", W'(flag), '0);

    // Test 6: reset in the middle of a core fill.
    size = AW'(40);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6a");
    rst_n = 1'b1;
    start = 1'b1;
    tick(); cyc = 0; start = 1'b0;
    go_to(5);
    chk("t6_filling", W'(mem_en), W'(1));
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6b");
    tick();
    chk_reset_outputs("t6c");
    rst_n = 1'b1;
    start = 1'b1;
    tick(); cyc = 0; start = 1'b0;
    chk("t6_restart_en", W'(mem_en), W'(1));
    chk("t6_restart_addr", W'(mem_addr), '0);
    go_to(17);
    chk("t6_cupd", W'(cache_updated), W'(1));
    chk("t6_cache_x", cache_x, exp_vec(0, 40, 0, 1));

    // controller_done with an empty FIFO, then a run with size 0.
    go_to(18);
    controller_done = 1'b1;
    tick(); controller_done = 1'b0;
    go_to(20);
    chk("t7_done_empty_fifo", W'(done), W'(1));
    size = '0;
    start = 1'b1;
    tick(); start = 1'b0;
    chk("t7_size0_no_read", W'(mem_en), '0);
    chk("t7_size0_busy", W'(done), '0);
    tick();
    chk("t7_size0_done", W'(done), W'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
